ball_bounce_ctrl: RTL and testbench

Rule engine for a Pong ball, running one decision per `game_clk` frame tick. It reads the current ball position and both paddle positions. It produces the direction and velocity that drive the ball position controller, plus a ball-recentre request, the scores and game-over status. It contains the serve/play/point/game-over state machine, wall and paddle bounce detection, speed-up on paddle hits, and score keeping.

---
 rtl/ball_bounce_ctrl.sv | 117 +++++++++++
 tb/tb_ball_bounce_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ball_bounce_ctrl.sv
// ball_bounce_ctrl: Pong rule engine with serve/play/point/game-over FSM,
// wall and paddle bounce detection, paddle speed-up and score keeping.
module ball_bounce_ctrl #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_DELAY    = 60,
  parameter int VEL_INIT       = 2,
  parameter int VEL_MAX        = 8,
  parameter int WIN_SCORE      = 9
) (
  input  logic       game_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] cur_x_ball,
  input  logic [9:0] cur_y_ball,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic       x_ball_dir,
  output logic       y_ball_dir,
  output logic [3:0] x_ball_vel,
  output logic [3:0] y_ball_vel,
  output logic       ball_reset,
  output logic       point_scored,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic x_dir_q, x_dir_d, y_dir_q, y_dir_d, br_q, br_d, ps_q, ps_d, go_q, go_d;
  logic sx_q, sx_d, sy_q, sy_d;
  logic [3:0] x_vel_q, x_vel_d, y_vel_q, y_vel_d, ls_q, ls_d, rs_q, rs_d, vel_inc;
  logic [10:0] x, y, lp, rp, vx2, vy2;
  logic top_hit, bot_hit, l_hit, r_hit, l_miss, r_miss, win;
  assign x   = {1'b0, cur_x_ball};
  assign y   = {1'b0, cur_y_ball};
  assign lp  = {1'b0, left_paddle_y};
  assign rp  = {1'b0, right_paddle_y};
  assign vx2 = {6'b0, x_vel_q, 1'b0};
  assign vy2 = {6'b0, y_vel_q, 1'b0};
  // Lookahead of two velocities: a direction change reaches the position one edge late
  assign top_hit = !y_dir_q && y <= vy2;
  assign bot_hit = y_dir_q && y + 11'(BALL_SIZE) + vy2 >= 11'(SCREEN_H);
  assign l_hit   = !x_dir_q && y + 11'(BALL_SIZE) > lp && y < lp + 11'(PADDLE_H) &&
                   x >= 11'(LEFT_PADDLE_X) && x <= 11'(LEFT_PADDLE_X + PADDLE_W) + vx2;
  assign r_hit   = x_dir_q && y + 11'(BALL_SIZE) > rp && y < rp + 11'(PADDLE_H) &&
                   x + 11'(BALL_SIZE) <= 11'(RIGHT_PADDLE_X) &&
                   x + 11'(BALL_SIZE) >= 11'(RIGHT_PADDLE_X) - vx2;
  assign l_miss  = !x_dir_q && !l_hit && x <= vx2;
  assign r_miss  = x_dir_q && !r_hit && x + 11'(BALL_SIZE) + vx2 >= 11'(SCREEN_W);
  assign vel_inc = (x_vel_q >= 4'(VEL_MAX)) ? 4'(VEL_MAX) : x_vel_q + 4'd1;
  assign win     = (sx_q ? ls_q : rs_q) == 4'(WIN_SCORE);
  always_ff @(posedge game_clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SERVE;
      SERVE:   if (cnt_q == 8'(SERVE_DELAY - 1)) state_d = PLAY;
      PLAY:    if (l_miss || r_miss) state_d = POINT;
      POINT:   state_d = win ? OVER : SERVE;
      OVER:    if (start) state_d = SERVE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = '0; x_dir_d = x_dir_q; y_dir_d = y_dir_q; x_vel_d = '0; y_vel_d = '0;
    br_d = 1'b1; ps_d = 1'b0; ls_d = ls_q; rs_d = rs_q; go_d = go_q; sx_d = sx_q; sy_d = sy_q;
    case (state_q)
      IDLE, OVER: if (start) begin ls_d = '0; rs_d = '0; go_d = 1'b0; end
      SERVE: begin
        cnt_d = cnt_q + 8'd1;
        if (state_d == PLAY) begin
          cnt_d = '0; br_d = 1'b0; x_vel_d = 4'(VEL_INIT); y_vel_d = 4'(VEL_INIT);
          x_dir_d = sx_q; y_dir_d = sy_q; sy_d = !sy_q;
        end
      end
      PLAY: begin
        br_d = 1'b0; x_vel_d = x_vel_q; y_vel_d = y_vel_q;
        y_dir_d = top_hit ? 1'b1 : bot_hit ? 1'b0 : y_dir_q;
        if (l_hit || r_hit) begin
          x_dir_d = !x_dir_q; x_vel_d = vel_inc;
        end else if (l_miss || r_miss) begin
          br_d = 1'b1; ps_d = 1'b1; x_vel_d = '0; y_vel_d = '0; sx_d = r_miss;
          rs_d = (l_miss && rs_q != 4'hF) ? rs_q + 4'd1 : rs_q;
          ls_d = (r_miss && ls_q != 4'hF) ? ls_q + 4'd1 : ls_q;
        end
      end
      POINT:   go_d = win;
      default: ;
    endcase
  end
  always_ff @(posedge game_clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0; x_dir_q <= 1'b1; y_dir_q <= 1'b1; x_vel_q <= '0; y_vel_q <= '0;
      br_q <= 1'b1; ps_q <= 1'b0; ls_q <= '0; rs_q <= '0; go_q <= 1'b0; sx_q <= 1'b1; sy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d; x_dir_q <= x_dir_d; y_dir_q <= y_dir_d; x_vel_q <= x_vel_d; y_vel_q <= y_vel_d;
      br_q <= br_d; ps_q <= ps_d; ls_q <= ls_d; rs_q <= rs_d; go_q <= go_d; sx_q <= sx_d; sy_q <= sy_d;
    end
  assign x_ball_dir   = x_dir_q;
  assign y_ball_dir   = y_dir_q;
  assign x_ball_vel   = x_vel_q;
  assign y_ball_vel   = y_vel_q;
  assign ball_reset   = br_q;
  assign point_scored = ps_q;
  assign left_score   = ls_q;
  assign right_score  = rs_q;
  assign game_over    = go_q;
endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// tb_ball_bounce_ctrl: directed and randomized frames checked against a rule-level model.
module tb_ball_bounce_ctrl;
  localparam int SD = 60;
  logic game_clk = 0, reset_n = 0, start = 0;
  logic [9:0] cx = 0, cy = 0, lpy = 0, rpy = 0;
  logic xd, yd, br, ps, go;
  logic [3:0] xv, yv, ls, rs;
  int errors = 0, checks = 0;
  int m_ph, m_cnt, m_xd, m_yd, m_xv, m_yv, m_br, m_ps, m_ls, m_rs, m_go, m_sx, m_sy, m_last;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  ball_bounce_ctrl dut (
    .game_clk(game_clk), .reset_n(reset_n), .start(start),
    .cur_x_ball(cx), .cur_y_ball(cy), .left_paddle_y(lpy), .right_paddle_y(rpy),
    .x_ball_dir(xd), .y_ball_dir(yd), .x_ball_vel(xv), .y_ball_vel(yv),
    .ball_reset(br), .point_scored(ps), .left_score(ls), .right_score(rs), .game_over(go)
  );

  always #5 game_clk = ~game_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = M_IDLE; m_cnt = 0; m_xd = 1; m_yd = 1; m_xv = 0; m_yv = 0; m_br = 1; m_ps = 0;
    m_ls = 0; m_rs = 0; m_go = 0; m_sx = 1; m_sy = 1; m_last = 0;
  endtask

  function automatic int inc_sat(input int v, input int lim);
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  task automatic model_step();
    int x, y, lp, rp, win;
    bit lh, rh, lm, rm;
    x = cx; y = cy; lp = lpy; rp = rpy;
    m_ps = 0;
    case (m_ph)
      M_IDLE, M_OVER:
        if (start) begin m_ls = 0; m_rs = 0; m_go = 0; m_ph = M_SERVE; m_cnt = 0; end
      M_SERVE:
        if (m_cnt == SD - 1) begin
          m_ph = M_PLAY; m_cnt = 0; m_br = 0; m_xv = 2; m_yv = 2;
          m_xd = m_sx; m_yd = m_sy; m_sy = 1 - m_sy;
        end else m_cnt++;
      M_PLAY: begin
        if (m_yd == 0 && y <= 2 * m_yv) m_yd = 1;
        else if (m_yd == 1 && y + 8 + 2 * m_yv >= 480) m_yd = 0;
        lh = m_xd == 0 && y + 8 > lp && y < lp + 64 && x >= 16 && x <= 24 + 2 * m_xv;
        rh = m_xd == 1 && y + 8 > rp && y < rp + 64 && x + 8 <= 616 && x + 8 >= 616 - 2 * m_xv;
        lm = m_xd == 0 && !lh && x <= 2 * m_xv;
        rm = m_xd == 1 && !rh && x + 8 + 2 * m_xv >= 640;
        if (lh || rh) begin
          m_xd = 1 - m_xd; m_xv = inc_sat(m_xv, 8);
        end else if (lm || rm) begin
          m_ph = M_POINT; m_ps = 1; m_br = 1; m_xv = 0; m_yv = 0;
          if (lm) begin m_rs = inc_sat(m_rs, 15); m_sx = 0; m_last = 1; end
          else    begin m_ls = inc_sat(m_ls, 15); m_sx = 1; m_last = 0; end
        end
      end
      default: begin
        win = ((m_last ? m_rs : m_ls) == 9);
        m_ph = win ? M_OVER : M_SERVE; m_go = win; m_cnt = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("x_dir", xd, m_xd);      check("y_dir", yd, m_yd);
    check("x_vel", xv, m_xv);      check("y_vel", yv, m_yv);
    check("ball_reset", br, m_br); check("point_scored", ps, m_ps);
    check("left_score", ls, m_ls); check("right_score", rs, m_rs);
    check("game_over", go, m_go);
  endtask

  task automatic frame(input int x, input int y, input int lp, input int rp, input bit st);
    cx = 10'(x); cy = 10'(y); lpy = 10'(lp); rpy = 10'(rp); start = st;
    model_step();
    @(posedge game_clk); #1;
    compare_all();
  endtask

  task automatic serve_wait(output int n);
    n = 0;
    while (br && n < 200) begin frame(320, 240, 0, 0, 0); n++; end
    check("serve_bound", int'(n < 200), 1);
  endtask

  task automatic reset_consts(input string tag);
    check({tag, "_xdir"}, xd, 1); check({tag, "_ydir"}, yd, 1);
    check({tag, "_xvel"}, xv, 0); check({tag, "_yvel"}, yv, 0);
    check({tag, "_br"}, br, 1);   check({tag, "_ps"}, ps, 0);
    check({tag, "_ls"}, ls, 0);   check({tag, "_rs"}, rs, 0);
    check({tag, "_go"}, go, 0);
  endtask

  initial begin
    int n, x, y, lp, rp;
    bit st;
    m_reset();
    #12 reset_consts("rst");
    reset_n = 1;
    frame(320, 240, 0, 0, 0);
    frame(320, 240, 0, 0, 1);
    serve_wait(n);
    check("start_latency", n, SD);
    check("serve_xvel", xv, 2); check("serve_yvel", yv, 2);
    check("serve_xdir", xd, 1); check("serve_ydir", yd, 1);
    frame(320, 470, 0, 0, 0); check("bottom_flip", yd, 0);
    frame(320, 5, 0, 0, 0);   check("top_noflip", yd, 0);
    frame(320, 4, 0, 0, 0);   check("top_flip", yd, 1); check("top_xdir", xd, 1);
    frame(606, 100, 0, 80, 0); check("rhit_dir", xd, 0); check("rhit_vel", xv, 3);
    frame(2, 100, 400, 0, 0);  check("lmiss_ps", ps, 1); check("lmiss_rs", rs, 1);
    serve_wait(n);
    check("point_latency", n, SD + 1); check("reserve_xdir", xd, 0);
    for (int k = 0; k < 5; k++)
      if (k % 2 == 0) frame(20, 100, 80, 0, 0);
      else            frame(606, 100, 0, 80, 0);
    check("ramp_vel", xv, 7); check("ramp_dir", xd, 1);
    frame(594, 100, 0, 80, 0); check("rhit7_dir", xd, 0); check("rhit7_vel", xv, 8);
    frame(20, 100, 80, 0, 0);  check("lhit8_vel", xv, 8);
    frame(594, 100, 0, 80, 0); check("rhit8_vel", xv, 8);
    frame(20, 100, 80, 0, 0);
    frame(630, 100, 0, 200, 0);
    check("rmiss_ps", ps, 1); check("rmiss_ls", ls, 1); check("rmiss_br", br, 1);
    frame(320, 100, 0, 0, 0); check("ps_pulse", ps, 0);
    serve_wait(n); check("rmiss_serve_xdir", xd, 1);
    n = 0;
    while (ls < 9 && n < 20) begin
      int w;
      serve_wait(w);
      frame(635, 240, 0, 0, 0);
      n++;
    end
    check("win_ls", ls, 9);
    frame(320, 240, 0, 0, 0);
    check("go_flag", go, 1); check("go_xvel", xv, 0); check("go_yvel", yv, 0);
    frame(320, 240, 0, 0, 0); check("go_hold_ls", ls, 9);
    frame(320, 240, 0, 0, 1);
    check("restart_ls", ls, 0); check("restart_rs", rs, 0); check("restart_go", go, 0);
    frame(320, 240, 0, 0, 0); check("restart_serve_br", br, 1);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom_range(10, 45);
        1: x = $urandom_range(585, 620);
        2: x = $urandom_range(0, 1) ? $urandom_range(0, 18) : $urandom_range(615, 639);
        default: x = $urandom_range(0, 1023);
      endcase
      y = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(455, 1023))
                                      : $urandom_range(0, 472);
      lp = y - $urandom_range(0, 100); if (lp < 0) lp = 0;
      rp = y - $urandom_range(0, 100); if (rp < 0) rp = 0;
      st = ($urandom_range(0, 7) == 0);
      frame(x, y, lp, rp, st);
    end
    reset_n = 0; #1 m_reset(); reset_n = 1;
    frame(320, 240, 0, 0, 1);
    serve_wait(n);
    frame(320, 240, 0, 0, 0);
    check("pre_reset_vel", xv, 2);
    #3 reset_n = 0;
    #1 reset_consts("async");
    m_reset();
    #2 reset_n = 1;
    frame(320, 240, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
